// File: rtl/regfile_sb.sv
// Register file: NRD combinational read ports, one posedge write port, and a per-register pending-write scoreboard.
// Latency: reads are zero-cycle combinational; writes and scoreboard updates take effect at the next posedge.
// Backpressure: none; the caller gates we with stall, and decode stalls on rd_busy/any_busy.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass with rd_busy masking.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  flush_n,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    output logic                  any_busy
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    // A write to r0 carries no meaning.
    logic wr_en;
    assign wr_en = we && (wa != '0);

    // Next state: a write stores data and retires the pending mark; a new producer set wins over a same-cycle clear.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        if (wr_en) begin
            rf_d[wa]   = wd;
            busy_d[wa] = 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
            busy_d[sb_addr] = 1'b1;
        end
        rf_d[0]   = '0;
        busy_d[0] = 1'b0;
    end

    // State registers; flush clears everything and overrides any same-cycle write or set.
    always_ff @(posedge clk) begin
        if (!flush_n) begin
            for (int k = 0; k < NREG; k++) begin
                rf_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    // Nothing is ever pending on r0, so this is the OR over real registers.
    assign any_busy = |busy_q;

    genvar i;
    generate
        for (i = 0; i < NRD; i++) begin : g_rd
            logic [ADDR_W-1:0] port_addr;
            logic [DATA_W-1:0] port_data;
            logic              port_busy;

            assign port_addr = ra[i*ADDR_W +: ADDR_W];

            // Read port: stored value and pending flag, optionally replaced by the write landing this cycle.
            always_comb begin
                port_data = rf_q[port_addr];
                port_busy = busy_q[port_addr];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (wa == port_addr)) begin
                    port_data = wd;
                    port_busy = 1'b0;
                end
`endif
                if (port_addr == '0) begin
                    port_data = '0;
                    port_busy = 1'b0;
                end
            end

            assign rd[i*DATA_W +: DATA_W] = port_data;
            assign rd_busy[i]             = port_busy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed scenarios followed by random traffic.
// Each cycle the driver pushes the expected outputs predicted by an array model; a negedge monitor pops and compares.
// Bypass expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        flush_n;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        any_busy;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
        .clk(clk), .flush_n(flush_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(any_busy)
    );

    typedef struct {
        bit          chk;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  bsy;
        logic        any;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural reference: plain arrays of register values and pending flags.
    logic [31:0] m_rf   [32];
    bit          m_busy [32];
    bit          m_known = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] exp_data(input logic [4:0] r, input logic w,
                                             input logic [4:0] a, input logic [31:0] d);
        if (r == 5'd0) return 32'd0;
        if (BYP && w && (a == r)) return d;
        return m_rf[r];
    endfunction

    function automatic logic exp_busy(input logic [4:0] r, input logic w, input logic [4:0] a);
        if (r == 5'd0) return 1'b0;
        if (BYP && w && (a == r)) return 1'b0;
        return m_busy[r];
    endfunction

    // One cycle: drive inputs, predict this cycle's outputs, then apply the clock edge to the model.
    task automatic step(input logic fl, input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic s, input logic [4:0] sa, input logic [4:0] r0, input logic [4:0] r1);
        exp_t e;
        bit   anyb;
        flush_n = fl; we = w; wa = a; wd = d; sb_set = s; sb_addr = sa; ra = {r1, r0};
        anyb = 1'b0;
        for (int k = 0; k < 32; k++) anyb |= m_busy[k];
        e.chk = m_known;
        e.rd0 = exp_data(r0, w, a, d);
        e.rd1 = exp_data(r1, w, a, d);
        e.bsy = {exp_busy(r1, w, a), exp_busy(r0, w, a)};
        e.any = anyb;
        exp_q.push_back(e);
        @(posedge clk);
        if (!fl) begin
            for (int k = 0; k < 32; k++) begin
                m_rf[k]   = 32'd0;
                m_busy[k] = 1'b0;
            end
            m_known = 1'b1;
        end else begin
            if (w && a != 5'd0) begin
                m_rf[a]   = d;
                m_busy[a] = 1'b0;
            end
            if (s && sa != 5'd0) m_busy[sa] = 1'b1;
        end
        #1;
    endtask

    // Monitor: outputs are combinational, so every cycle presents one response to check.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                n_checks += 4;
                if (rd[31:0] !== e.rd0) begin
                    n_fail++;
                    $display("FAIL rd0 t=%0t ra0=%0d got=%h want=%h", $time, ra[4:0], rd[31:0], e.rd0);
                end
                if (rd[63:32] !== e.rd1) begin
                    n_fail++;
                    $display("FAIL rd1 t=%0t ra1=%0d got=%h want=%h", $time, ra[9:5], rd[63:32], e.rd1);
                end
                if (rd_busy !== e.bsy) begin
                    n_fail++;
                    $display("FAIL rd_busy t=%0t ra=%h got=%b want=%b", $time, ra, rd_busy, e.bsy);
                end
                if (any_busy !== e.any) begin
                    n_fail++;
                    $display("FAIL any_busy t=%0t got=%b want=%b", $time, any_busy, e.any);
                end
            end
        end
    end

    initial begin
        logic [4:0]  a0, a1, wadr, sadr;
        logic        w, s, fl;
        flush_n = 1'b0; we = 1'b0; wa = '0; wd = '0; sb_set = 1'b0; sb_addr = '0; ra = '0;
        for (int k = 0; k < 32; k++) begin
            m_rf[k] = 32'd0;
            m_busy[k] = 1'b0;
        end
        @(posedge clk); #1;

        // Reset held two cycles with a write and a set pending; both must be discarded.
        step(0, 1, 3, 32'hDEADBEEF, 1, 4, 3, 4);
        step(0, 1, 3, 32'hDEADBEEF, 1, 4, 3, 4);
        step(1, 0, 0, 0, 0, 0, 3, 4);

        // Basic write/read and r0 behaviour.
        step(1, 1, 5, 32'h12345678, 0, 0, 5, 0);
        step(1, 1, 0, 32'hFFFFFFFF, 0, 0, 5, 0);
        step(1, 0, 0, 0, 1, 0, 5, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Same-cycle write with both ports reading it.
        step(1, 1, 7, 32'h11, 0, 0, 0, 0);
        step(1, 1, 7, 32'h22, 0, 0, 7, 7);
        step(1, 0, 0, 0, 0, 0, 7, 7);

        // Load hazard on r9.
        step(1, 0, 0, 0, 1, 9, 0, 0);
        step(1, 0, 0, 0, 0, 0, 9, 0);
        step(1, 0, 0, 0, 0, 0, 9, 0);
        step(1, 1, 9, 32'h55, 0, 0, 9, 9);
        step(1, 0, 0, 0, 0, 0, 9, 0);

        // Set and clear colliding on r6, then split across r10/r6.
        step(1, 0, 0, 0, 1, 6, 6, 0);
        step(1, 1, 6, 32'h66, 1, 6, 6, 6);
        step(1, 1, 6, 32'h67, 1, 10, 6, 10);
        step(1, 0, 0, 0, 0, 0, 6, 10);

        // Flush in the middle of pending loads and a write.
        step(1, 1, 2, 32'hAA, 1, 2, 0, 0);
        step(1, 0, 0, 0, 1, 3, 2, 3);
        step(0, 1, 2, 32'hBB, 0, 0, 2, 3);
        step(1, 0, 0, 0, 0, 0, 2, 3);

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            fl   = ($urandom_range(0, 49) != 0);
            w    = $urandom_range(0, 1);
            s    = ($urandom_range(0, 2) == 0);
            wadr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            sadr = 5'($urandom_range(0, 7));
            a0   = ($urandom_range(0, 2) == 0) ? wadr : 5'($urandom_range(0, 7));
            a1   = ($urandom_range(0, 3) == 0) ? wadr : 5'($urandom_range(0, 31));
            step(fl, w, wadr, $urandom, s, sadr, a0, a1);
        end

        // Let the monitor drain, with a bounded wait.
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the pipeline's 3-port register file. It provides NRD combinational read ports, one posedge write port with write-to-read bypass, and a per-register pending-write scoreboard. Decode uses the scoreboard busy flags to stall on in-flight loads. It sits in decode, is written from the ME writeback path, and replaces the negedge-write register file.

Parameters:
DATA_W, 32, register width in bits.
ADDR_W, 5, register address width; the file holds 2**ADDR_W entries.
NRD, 2, number of read ports (1..4).

Ports:
clk  input  1  clock; all state updates on posedge.
flush_n  input  1  reset, synchronous, active-low.
ra  input  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
rd  output  NRD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
rd_busy  output  NRD  port i's register has a pending, not-yet-resolved write.
we  input  1  write enable; caller gates it with stall.
wa  input  ADDR_W  write address.
wd  input  DATA_W  write data.
sb_set  input  1  mark register sb_addr as pending (load issued).
sb_addr  input  ADDR_W  scoreboard set address.
any_busy  output  1  OR of the busy bits of all registers.

Behaviour:
- Reset (flush_n=0 at posedge): all registers clear to 0 and all busy bits clear.
  - Result after the edge: rd = 0 on every port, rd_busy = 0, any_busy = 0.
  - Reset overrides we and sb_set in the same cycle.
- Register 0:
  - Reads always return 0 and rd_busy is always 0 for address 0.
  - Writes to address 0 are dropped; sb_set to address 0 is ignored.
- Write: at posedge, if we and wa != 0, then rf[wa] <= wd. This is the only write edge; there is no negedge logic.
- Read: rd for port i is combinational from ra[i], with zero-cycle latency.
- Bypass (REGFILE_BYPASS_EN defined): if we and wa == ra[i] and wa != 0, rd[i] = wd in the same cycle.
  - Every port is bypassed independently.
  - Multiple ports may read the same address.
- Scoreboard, one busy bit per register, updated at posedge:
  - Clear: if we and wa != 0, busy[wa] <= 0.
  - Set: if sb_set and sb_addr != 0, busy[sb_addr] <= 1.
  - Set and clear on the same address in the same cycle: set wins (a new producer was issued).
  - Set of an already-busy register: stays 1; the scoreboard holds no count.
- rd_busy[i] = busy[ra[i]].
  - With REGFILE_BYPASS_EN, it is additionally masked to 0 when we and wa == ra[i] (the write resolves the hazard this cycle).
- any_busy is combinational from the current busy bits. It is not masked by we.
- wa/ra compares are full ADDR_W bits; there is no wrap or truncation.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: the write-to-read data bypass and the rd_busy masking apply as above. Decode reads a value written in the same cycle.
- Undefined: rd always returns the stored array value, so the old value is seen during the write cycle. rd_busy = busy[ra[i]] unmasked, staying 1 through the write cycle and dropping the cycle after. The pipeline must then stall one extra cycle.

Test Plan:
- Reset: hold flush_n=0 for 2 cycles with we=1, wa=3, wd=0xDEADBEEF, sb_set=1, sb_addr=4. After release, ra={3,4} -> rd={0,0}, rd_busy=00, any_busy=0.
- Basic write/read and r0: we=1, wa=5, wd=0x12345678. Next cycle ra[0]=5 -> 0x12345678. Then we=1, wa=0, wd=0xFFFFFFFF; ra[1]=0 -> 0, rd_busy[1]=0.
- Bypass (REGFILE_BYPASS_EN): rf[7]=0x11. In the same cycle drive we=1, wa=7, wd=0x22, ra={7,7} -> rd={0x22,0x22}. Without the macro -> {0x11,0x11}, and 0x22 appears next cycle.
- Scoreboard load hazard: sb_set=1, sb_addr=9. Next cycle ra[0]=9 -> rd_busy[0]=1, any_busy=1. Two cycles later we=1, wa=9, wd=0x55 -> rd_busy[0]=0 that cycle with bypass, rd=0x55. The following cycle busy[9]=0 and any_busy=0.
- Simultaneous set/clear: busy[6]=1. In one cycle we=1, wa=6 with sb_set=1, sb_addr=6 -> next cycle busy[6]=1, rf[6]=wd. Separately, sb_set to address 10 with a write to address 6 -> busy[10]=1 and busy[6]=0.
- Reset mid-operation: busy[2]=busy[3]=1 and rf[2]=0xAA. Pulse flush_n=0 for 1 cycle while we=1, wa=2 -> all busy=0 and rf[2]=0. The write is discarded.
